// File: rtl/code_defs_pkg.sv
// -----------------------------------------------------------------------------
// code_defs_pkg
// Shared definitions for the PCS link controller:
//   link_ctrl_state_t : sequencer states (encoding is visible on o_state)
//   SYNC_DATA/CTRL    : the two legal 64b/66b sync header codes
//   is_bad_header     : true for a sync header that is neither data nor control
// -----------------------------------------------------------------------------
package code_defs_pkg;

  typedef enum logic [2:0] {
    XVER_WAIT = 3'd0,
    TX_REL    = 3'd1,
    RX_REL    = 3'd2,
    LOCK_WAIT = 3'd3,
    LINK_UP   = 3'd4,
    XVER_RST  = 3'd5
  } link_ctrl_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  function automatic logic is_bad_header(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_link_ctrl_if.sv
// -----------------------------------------------------------------------------
// pcs_link_ctrl_if
// Status inputs and reset/status outputs of the link controller.
//   i_xver_tx_done / i_xver_rx_done : transceiver reset-done (synchronised)
//   i_rx_header / i_rx_header_valid : sync header stream from the gearbox
//   i_block_lock                    : block lock indication
//   o_tx_reset / o_rx_reset         : PCS reset outputs
//   o_xver_rx_reset                 : transceiver rx datapath reset request
//   o_link_up / o_hi_ber            : link status
//   o_retry_count / o_state         : debug visibility
// slave modport is the controller side, master the driving side.
// -----------------------------------------------------------------------------
interface pcs_link_ctrl_if #(
  parameter int RETRY_WIDTH = 8
);
  logic                   i_xver_tx_done;
  logic                   i_xver_rx_done;
  logic [1:0]             i_rx_header;
  logic                   i_rx_header_valid;
  logic                   i_block_lock;
  logic                   o_tx_reset;
  logic                   o_rx_reset;
  logic                   o_xver_rx_reset;
  logic                   o_link_up;
  logic                   o_hi_ber;
  logic [RETRY_WIDTH-1:0] o_retry_count;
  logic [2:0]             o_state;

  modport master (
    output i_xver_tx_done, i_xver_rx_done, i_rx_header, i_rx_header_valid, i_block_lock,
    input  o_tx_reset, o_rx_reset, o_xver_rx_reset, o_link_up, o_hi_ber, o_retry_count, o_state
  );

  modport slave (
    input  i_xver_tx_done, i_xver_rx_done, i_rx_header, i_rx_header_valid, i_block_lock,
    output o_tx_reset, o_rx_reset, o_xver_rx_reset, o_link_up, o_hi_ber, o_retry_count, o_state
  );
endinterface

// File: rtl/pcs_link_ctrl_ber_monitor.sv
// -----------------------------------------------------------------------------
// ber_monitor
// Counts valid sync headers in fixed windows and flags a high bit-error rate.
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_enable        : count only while the link is up
//   i_clear         : clear counters and flag (has priority over counting)
//   i_header/i_valid: header stream
//   o_hi_ber        : registered hi-BER flag
//   o_hi_ber_next   : value o_hi_ber takes at the next edge (lets the parent
//                     register link_up coincident with the flag)
// -----------------------------------------------------------------------------
module ber_monitor
  import code_defs_pkg::*;
#(
  parameter int BER_WINDOW = 125000,
  parameter int BER_THRESH = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [1:0] i_header,
  input  logic       i_valid,
  output logic       o_hi_ber,
  output logic       o_hi_ber_next
);

  localparam int WIN_W = $clog2(BER_WINDOW);
  localparam int BAD_W = $clog2(BER_THRESH + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
  localparam logic [BAD_W-1:0] BAD_MAX  = BAD_W'(BER_THRESH);

  logic [WIN_W-1:0] win_cnt_r, win_cnt_n_s;
  logic [BAD_W-1:0] bad_cnt_r, bad_cnt_n_s, bad_inc_s;
  logic             hi_ber_r, hi_ber_n_s;

  // Window/bad-count next-state; bad count saturates so >= THRESH reduces to ==
  always_comb begin
    win_cnt_n_s = win_cnt_r;
    bad_cnt_n_s = bad_cnt_r;
    hi_ber_n_s  = hi_ber_r;
    bad_inc_s   = bad_cnt_r;
    if (i_clear) begin
      win_cnt_n_s = '0;
      bad_cnt_n_s = '0;
      hi_ber_n_s  = 1'b0;
    end else if (i_enable && i_valid) begin
      if (is_bad_header(i_header) && (bad_cnt_r != BAD_MAX)) begin
        bad_inc_s = bad_cnt_r + BAD_W'(1);
      end else begin
        bad_inc_s = bad_cnt_r;
      end
      if (win_cnt_r == WIN_LAST) begin
        // window end: verdict includes this final header, then restart
        hi_ber_n_s  = (bad_inc_s == BAD_MAX);
        win_cnt_n_s = '0;
        bad_cnt_n_s = '0;
      end else begin
        win_cnt_n_s = win_cnt_r + WIN_W'(1);
        bad_cnt_n_s = bad_inc_s;
        if (bad_inc_s == BAD_MAX) begin
          hi_ber_n_s = 1'b1;
        end else begin
          hi_ber_n_s = hi_ber_r;
        end
      end
    end else begin
      win_cnt_n_s = win_cnt_r;
      bad_cnt_n_s = bad_cnt_r;
      hi_ber_n_s  = hi_ber_r;
    end
  end

  // Counter and flag registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      win_cnt_r <= '0;
      bad_cnt_r <= '0;
      hi_ber_r  <= 1'b0;
    end else begin
      win_cnt_r <= win_cnt_n_s;
      bad_cnt_r <= bad_cnt_n_s;
      hi_ber_r  <= hi_ber_n_s;
    end
  end

  assign o_hi_ber      = hi_ber_r;
  assign o_hi_ber_next = hi_ber_n_s;

endmodule

// File: rtl/pcs_link_ctrl.sv
// -----------------------------------------------------------------------------
// pcs_link_ctrl
// Bring-up and supervision sequencer for the 32-bit PCS (xver_rx_clk domain).
// Waits for transceiver reset-done, releases PCS tx then rx reset, waits for
// block lock (retrying with a transceiver rx reset on timeout) and supervises
// the link with a hi-BER monitor.
//   i_clk   : xver_rx_clk
//   i_reset : asynchronous, active-high
//   bus     : pcs_link_ctrl_if.slave (status in, resets/status out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module pcs_link_ctrl
  import code_defs_pkg::*;
#(
  parameter int RELEASE_DELAY   = 8,
  parameter int LOCK_TIMEOUT    = 1000000,
  parameter int XVER_RST_CYCLES = 16,
  parameter int BER_WINDOW      = 125000,
  parameter int BER_THRESH      = 16,
  parameter int RETRY_WIDTH     = 8
) (
  input logic            i_clk,
  input logic            i_reset,
  pcs_link_ctrl_if.slave bus
);

  // one delay counter serves both the release steps and the xver reset hold
  localparam int DLY_MAX = (RELEASE_DELAY > XVER_RST_CYCLES) ? RELEASE_DELAY - 1 : XVER_RST_CYCLES - 1;
  localparam int DLY_W   = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT);
  localparam logic [DLY_W-1:0] REL_LAST = DLY_W'(RELEASE_DELAY - 1);
  localparam logic [DLY_W-1:0] XR_LAST  = DLY_W'(XVER_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = {RETRY_WIDTH{1'b1}};

  link_ctrl_state_t       state_r, state_n_s;
  logic                   tx_reset_r, tx_reset_n_s;
  logic                   rx_reset_r, rx_reset_n_s;
  logic                   xver_rst_r, xver_rst_n_s;
  logic                   link_up_r, link_up_n_s;
  logic [RETRY_WIDTH-1:0] retry_r, retry_n_s;
  logic [DLY_W-1:0]       dly_cnt_r, dly_cnt_n_s;
  logic [TMO_W-1:0]       tmo_cnt_r, tmo_cnt_n_s;
  logic                   rx_low_seen_r, rx_low_seen_n_s;
  logic                   low_seen_s;
  logic                   ber_enable_s, ber_clear_s;
  logic                   hi_ber_s, hi_ber_next_s;

  // Next-state and next-output logic
  always_comb begin
    state_n_s       = state_r;
    tx_reset_n_s    = tx_reset_r;
    rx_reset_n_s    = rx_reset_r;
    xver_rst_n_s    = xver_rst_r;
    retry_n_s       = retry_r;
    dly_cnt_n_s     = dly_cnt_r;
    tmo_cnt_n_s     = tmo_cnt_r;
    rx_low_seen_n_s = rx_low_seen_r;
    low_seen_s      = rx_low_seen_r | ~bus.i_xver_rx_done;
    if ((state_r != XVER_WAIT) && !bus.i_xver_tx_done) begin
      // loss of tx done restarts the whole bring-up; retries are kept
      state_n_s    = XVER_WAIT;
      tx_reset_n_s = 1'b1;
      rx_reset_n_s = 1'b1;
      xver_rst_n_s = 1'b0;
    end else if ((state_r inside {TX_REL, RX_REL, LOCK_WAIT, LINK_UP}) && !bus.i_xver_rx_done) begin
      state_n_s    = XVER_WAIT;
      rx_reset_n_s = 1'b1;
    end else begin
      case (state_r)
        XVER_WAIT: begin
          if (bus.i_xver_tx_done && bus.i_xver_rx_done) begin
            state_n_s   = TX_REL;
            dly_cnt_n_s = '0;
          end else begin
            state_n_s = XVER_WAIT;
          end
        end
        TX_REL: begin
          if (dly_cnt_r == REL_LAST) begin
            state_n_s    = RX_REL;
            tx_reset_n_s = 1'b0;
            dly_cnt_n_s  = '0;
          end else begin
            dly_cnt_n_s = dly_cnt_r + DLY_W'(1);
          end
        end
        RX_REL: begin
          if (dly_cnt_r == REL_LAST) begin
            state_n_s    = LOCK_WAIT;
            rx_reset_n_s = 1'b0;
            tmo_cnt_n_s  = '0;
          end else begin
            dly_cnt_n_s = dly_cnt_r + DLY_W'(1);
          end
        end
        LOCK_WAIT: begin
          // lock is tested first so it wins over a coincident timeout
          if (bus.i_block_lock) begin
            state_n_s = LINK_UP;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_n_s       = XVER_RST;
            xver_rst_n_s    = 1'b1;
            rx_reset_n_s    = 1'b1;
            retry_n_s       = (retry_r != RETRY_MAX) ? retry_r + RETRY_WIDTH'(1) : retry_r;
            dly_cnt_n_s     = '0;
            rx_low_seen_n_s = 1'b0;
          end else begin
            tmo_cnt_n_s = tmo_cnt_r + TMO_W'(1);
          end
        end
        LINK_UP: begin
          if (!bus.i_block_lock) begin
            state_n_s   = LOCK_WAIT;
            tmo_cnt_n_s = '0;
          end else begin
            state_n_s = LINK_UP;
          end
        end
        XVER_RST: begin
          // a done left high from before the reset must not end the hold:
          // exit needs rx_done to have been seen low during this state
          rx_low_seen_n_s = low_seen_s;
          if ((dly_cnt_r == XR_LAST) && low_seen_s) begin
            state_n_s    = XVER_WAIT;
            xver_rst_n_s = 1'b0;
          end else if (dly_cnt_r != XR_LAST) begin
            dly_cnt_n_s = dly_cnt_r + DLY_W'(1);
          end else begin
            dly_cnt_n_s = dly_cnt_r;
          end
        end
        default: begin
          state_n_s    = XVER_WAIT;
          tx_reset_n_s = 1'b1;
          rx_reset_n_s = 1'b1;
          xver_rst_n_s = 1'b0;
        end
      endcase
    end
  end

  // BER monitor runs only while staying in LINK_UP; entry and exit clear it
  always_comb begin
    ber_enable_s = (state_r == LINK_UP);
    ber_clear_s  = (state_r != LINK_UP) || (state_n_s != LINK_UP);
    link_up_n_s  = (state_n_s == LINK_UP) && !hi_ber_next_s;
  end

  ber_monitor #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_monitor (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (ber_enable_s),
    .i_clear       (ber_clear_s),
    .i_header      (bus.i_rx_header),
    .i_valid       (bus.i_rx_header_valid),
    .o_hi_ber      (hi_ber_s),
    .o_hi_ber_next (hi_ber_next_s)
  );

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= XVER_WAIT;
      tx_reset_r    <= 1'b1;
      rx_reset_r    <= 1'b1;
      xver_rst_r    <= 1'b0;
      link_up_r     <= 1'b0;
      retry_r       <= '0;
      dly_cnt_r     <= '0;
      tmo_cnt_r     <= '0;
      rx_low_seen_r <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      tx_reset_r    <= tx_reset_n_s;
      rx_reset_r    <= rx_reset_n_s;
      xver_rst_r    <= xver_rst_n_s;
      link_up_r     <= link_up_n_s;
      retry_r       <= retry_n_s;
      dly_cnt_r     <= dly_cnt_n_s;
      tmo_cnt_r     <= tmo_cnt_n_s;
      rx_low_seen_r <= rx_low_seen_n_s;
    end
  end

  assign bus.o_tx_reset      = tx_reset_r;
  assign bus.o_rx_reset      = rx_reset_r;
  assign bus.o_xver_rx_reset = xver_rst_r;
  assign bus.o_link_up       = link_up_r;
  assign bus.o_hi_ber        = hi_ber_s;
  assign bus.o_retry_count   = retry_r;
  assign bus.o_state         = state_r;

endmodule
